// File: rtl/adder_pipe.sv
// Pipelined chunked ripple-carry adder with carry-in, carry-out and signed overflow, behind a valid/ready stream.
// Optional lower-part-OR approximation of the APPROX_BITS LSBs is enabled by defining ADDER_APPROX_EN.
module adder_pipe #(
  parameter int WIDTH       = 32,
  parameter int CHUNK       = 8,
  parameter int APPROX_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

`ifdef ADDER_APPROX_EN
  localparam int APX = APPROX_BITS;
`else
  // Exact build: the approximate region is forced to zero width.
  localparam int APX = APPROX_BITS * 0;
`endif

  // Handshake: a beat moves on a port when valid & ready are both high at a
  // rising edge. The whole pipe advances as one (adv); a stalled output
  // freezes every stage, so in_ready depends only on out_ready and out_valid.
  logic adv;
  logic ovf_r;

  // Adds one chunk bit by bit; bits below APX are OR-ed and only bit APX-1
  // produces a carry (a & b), so in_cin is ignored when APX > 0.
  function automatic logic [CHUNK:0] chunk_add(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             cin,
    input int               base
  );
    logic [CHUNK-1:0] s;
    logic             c;
    c = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (base + i < APX) begin
        s[i] = a[i] | b[i];
        c    = (base + i == APX - 1) ? (a[i] & b[i]) : 1'b0;
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return {c, s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO - CHUNK;

    logic [CHUNK-1:0]    ca;
    logic [CHUNK-1:0]    cb;
    logic                ci;
    logic                vi;
    logic [CHUNK:0]      r;
    logic [LO+CHUNK-1:0] s_n;
    logic                v_r;
    logic                c_r;
    logic [LO+CHUNK-1:0] s_r;

    if (k == 0) begin : g_src
      assign ca  = in_a[CHUNK-1:0];
      assign cb  = in_b[CHUNK-1:0];
      assign ci  = in_cin;
      assign vi  = in_valid;
      assign s_n = r[CHUNK-1:0];
    end else begin : g_src
      assign ca  = g_stage[k-1].g_skew.a_r[CHUNK-1:0];
      assign cb  = g_stage[k-1].g_skew.b_r[CHUNK-1:0];
      assign ci  = g_stage[k-1].c_r;
      assign vi  = g_stage[k-1].v_r;
      assign s_n = {r[CHUNK-1:0], g_stage[k-1].s_r};
    end

    assign r = chunk_add(ca, cb, ci, LO);

    // Bubbles travel like beats: v_r simply follows the upstream valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= vi;
        c_r <= r[CHUNK];
        s_r <= s_n;
      end
    end

    // Operand bits not yet added ride along in skew registers.
    if (REM > 0) begin : g_skew
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;
      logic [REM-1:0] a_n;
      logic [REM-1:0] b_n;

      if (k == 0) begin : g_op
        assign a_n = in_a[WIDTH-1:CHUNK];
        assign b_n = in_b[WIDTH-1:CHUNK];
      end else begin : g_op
        assign a_n = g_stage[k-1].g_skew.a_r[REM+CHUNK-1:CHUNK];
        assign b_n = g_stage[k-1].g_skew.b_r[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv) begin
          a_r <= a_n;
          b_r <= b_n;
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_r;
  assign out_sum   = g_stage[LAST].s_r;
  assign out_cout  = g_stage[LAST].c_r;
  assign out_ovf   = ovf_r;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (adv) begin
      ovf_r <= g_stage[LAST].r[CHUNK] ^ g_stage[LAST].r[CHUNK-1]
             ^ g_stage[LAST].ca[CHUNK-1] ^ g_stage[LAST].cb[CHUNK-1];
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (exact build, 32-bit, 8-bit chunks): directed corner beats, backpressure,
// mid-stream reset and random traffic, all scored against a plain-arithmetic reference.
module tb_adder_pipe;

  localparam int W      = 32;
  localparam int C      = 8;
  localparam int STAGES = W / C;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;
  int           n_vec = 0;
  int           n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .CHUNK(C), .APPROX_BITS(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Reference: {ovf, cout, sum} from wide integer addition and sign rules.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] w;
    logic       ovf;
    w   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (w[W-1] != a[W-1]);
    return {ovf, w};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: sampled on the falling edge, mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %0h with no beat outstanding",
                   {out_ovf, out_cout, out_sum});
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 64'({out_ovf, out_cout, out_sum}), 64'(mon_e));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(in_a, in_b, in_cin));
    end
  end

  // driver tasks
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int acc;
    int cyc;
    logic ok;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_sum", 64'(out_sum), 64'd0);
    check("reset_out_cout", 64'(out_cout), 64'd0);
    check("reset_out_ovf", 64'(out_ovf), 64'd0);

    // single beat latency: 0xFFFFFFFF + 1
    out_ready = 1'b1;
    drive('1, 32'd1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(STAGES));
    drain();

    // back-to-back overflow corners
    drive(32'h7FFF_FFFF, 32'h0, 1'b1);
    @(posedge clk); #1;
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    drain();

    // backpressure: pipe fills to STAGES beats, then in_ready drops
    out_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 2 * STAGES; i++) begin
      drive(W'(i), W'(i), 1'b0);
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (!ok) break;
      acc++;
    end
    in_valid = 1'b0;
    check("accepted_before_stall", 64'(acc), 64'(STAGES));
    check("stall_in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_out_sum", 64'(out_sum), 64'h2);
    drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    drive(32'd5, 32'd5, 1'b0);
    @(posedge clk); #1;
    drive(32'd10, 32'd10, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2 * STAGES) begin
      @(posedge clk); #1;
    end
    check("midrst_no_stale", 64'(out_valid), 64'd0);

    // random traffic
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      if (!in_valid && $urandom_range(0, 3) != 0)
        drive(pick(), pick(), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (ok) begin
        acc++;
        in_valid = 1'b0;
      end
    end
    check("random_beats", 64'(acc), 64'd10000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
